// File: rtl/mc_pkg.sv
// mc_pkg: shared types and constants for the fetch/memory stage of the
// multicycle controller.
//   state_t      - memory-access FSM states (idle / waiting on mem_ready)
//   NOP_INSTR    - instruction loaded into IR when a fetch times out
//   *_LSB / *_W  - instruction-register field positions and widths
//   CNT_W        - wait-counter width (covers MAX_WAIT up to 255)
package mc_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam logic [31:0] NOP_INSTR = 32'hE1A0_0000;

    localparam int COND_LSB = 28;
    localparam int OP_LSB   = 26;
    localparam int FUNC_LSB = 20;
    localparam int RN_LSB   = 16;
    localparam int RD_LSB   = 12;
    localparam int RM_LSB   = 0;

    localparam int COND_W = 4;
    localparam int OP_W   = 2;
    localparam int FUNC_W = 6;
    localparam int REG_W  = 4;

    localparam int CNT_W = 8;

endpackage

// File: rtl/mc_mem_wait_fsm.sv
// mc_mem_wait_fsm: drives the single memory port and tracks wait states.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   acc, fetch, store     access request from the controller (IDLE only)
//   req_addr, req_wdata   address / store data presented in IDLE
//   mem_ready             memory completes the access this cycle
//   mem_req, mem_we,
//   mem_addr, mem_wdata   memory port outputs
//   stall                 controller hold
//   done, timeout         access completed / gave up this cycle
//   done_fetch, done_store  kind of the access that finishes this cycle
module mc_mem_wait_fsm
    import mc_pkg::*;
#(
    parameter int AW       = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          acc,
    input  logic          fetch,
    input  logic          store,
    input  logic [AW-1:0] req_addr,
    input  logic [AW-1:0] req_wdata,
    input  logic          mem_ready,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [AW-1:0] mem_wdata,
    output logic          stall,
    output logic          done,
    output logic          timeout,
    output logic          done_fetch,
    output logic          done_store
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] count_reg;
    logic [AW-1:0]    addr_reg;
    logic [AW-1:0]    wdata_reg;
    logic             we_reg;
    logic             fetch_reg;
    logic             at_max;

    assign at_max = (count_reg == MAX_CNT);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (acc && !mem_ready) state_next = ST_WAIT;
            ST_WAIT: if (mem_ready || at_max) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Access latches and wait counter. The controller is frozen while we
    // wait, but its inputs are still not trusted, so the request is captured
    // on the cycle the wait starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            we_reg    <= 1'b0;
            fetch_reg <= 1'b0;
        end else if (state_reg == ST_IDLE) begin
            if (acc && !mem_ready) begin
                count_reg <= CNT_W'(1);
                addr_reg  <= req_addr;
                wdata_reg <= req_wdata;
                we_reg    <= store;
                fetch_reg <= fetch;
            end
        end else if (!mem_ready && !at_max) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    // Output logic
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = req_addr;
        mem_wdata  = req_wdata;
        stall      = 1'b0;
        done       = 1'b0;
        timeout    = 1'b0;
        done_fetch = fetch;
        done_store = store;
        case (state_reg)
            ST_IDLE: begin
                mem_req = acc;
                mem_we  = store;
                stall   = acc && !mem_ready;
                done    = acc && mem_ready;
            end
            ST_WAIT: begin
                mem_req    = 1'b1;
                mem_we     = we_reg;
                mem_addr   = addr_reg;
                mem_wdata  = wdata_reg;
                stall      = !mem_ready && !at_max;
                done       = mem_ready;
                timeout    = !mem_ready && at_max;
                done_fetch = fetch_reg;
                done_store = we_reg;
            end
            default: ;
        endcase
        // While reset is held the port must go quiet immediately, even
        // though IDLE would otherwise echo a live request from the controller.
        if (!rst_n) begin
            mem_req = 1'b0;
            mem_we  = 1'b0;
            stall   = 1'b0;
            done    = 1'b0;
            timeout = 1'b0;
        end
    end

endmodule

// File: rtl/mc_fetch_mem_unit.sv
// mc_fetch_mem_unit: upstream stage of the multicycle controller.
// Holds PC, IR and DR, issues fetches and data accesses on one memory port
// (via mc_mem_wait_fsm) and slices IR into controller fields.
// Ports:
//   CLK, RESET_N                         clock, asynchronous active-low reset
//   IRWrite, PCWrite, AdrSrc, MemWrite   controller strobes
//   Result, ALUResult, WriteData         next PC, data address, store data
//   mem_req/mem_we/mem_addr/mem_wdata    memory request side
//   mem_rdata, mem_ready                 memory response side
//   Stall                                controller hold
//   PC, Instr, ReadData                  PC, IR, DR contents
//   Cond, Op, Func, Rn, Rd, Rm           IR fields
//   BusError                             sticky access-timeout flag
module mc_fetch_mem_unit
    import mc_pkg::*;
#(
    parameter int          AW       = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MAX_WAIT = 15
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              IRWrite,
    input  logic              PCWrite,
    input  logic              AdrSrc,
    input  logic              MemWrite,
    input  logic [AW-1:0]     Result,
    input  logic [AW-1:0]     ALUResult,
    input  logic [AW-1:0]     WriteData,
    output logic              mem_req,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [AW-1:0]     mem_wdata,
    input  logic [AW-1:0]     mem_rdata,
    input  logic              mem_ready,
    output logic              Stall,
    output logic [AW-1:0]     PC,
    output logic [AW-1:0]     Instr,
    output logic [AW-1:0]     ReadData,
    output logic [COND_W-1:0] Cond,
    output logic [OP_W-1:0]   Op,
    output logic [FUNC_W-1:0] Func,
    output logic [REG_W-1:0]  Rn,
    output logic [REG_W-1:0]  Rd,
    output logic [REG_W-1:0]  Rm,
    output logic              BusError
);

    logic [AW-1:0] pc_reg, ir_reg, dr_reg;
    logic          bus_err_reg;
    logic          acc, store;
    logic          done, timeout, done_fetch, done_store, finish;

    assign acc    = IRWrite | AdrSrc;
    assign store  = AdrSrc & MemWrite;
    assign finish = done | timeout;

    mc_mem_wait_fsm #(
        .AW       (AW),
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_fsm (
        .clk        (CLK),
        .rst_n      (RESET_N),
        .acc        (acc),
        .fetch      (IRWrite),
        .store      (store),
        .req_addr   (AdrSrc ? ALUResult : pc_reg),
        .req_wdata  (WriteData),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .stall      (Stall),
        .done       (done),
        .timeout    (timeout),
        .done_fetch (done_fetch),
        .done_store (done_store)
    );

    // The controller keeps PCWrite asserted through a stall, so gating on
    // Stall makes the PC update land on the completion (or timeout) cycle.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pc_reg      <= AW'(RESET_PC);
            ir_reg      <= '0;
            dr_reg      <= '0;
            bus_err_reg <= 1'b0;
        end else begin
            if (PCWrite && !Stall) pc_reg <= Result;
            if (finish && done_fetch) ir_reg <= timeout ? AW'(NOP_INSTR) : mem_rdata;
            if (finish && !done_fetch && !done_store) dr_reg <= timeout ? '0 : mem_rdata;
            if (timeout) bus_err_reg <= 1'b1;
        end
    end

    assign PC       = pc_reg;
    assign Instr    = ir_reg;
    assign ReadData = dr_reg;
    assign BusError = bus_err_reg;

    assign Cond = ir_reg[COND_LSB +: COND_W];
    assign Op   = ir_reg[OP_LSB   +: OP_W];
    assign Func = ir_reg[FUNC_LSB +: FUNC_W];
    assign Rn   = ir_reg[RN_LSB   +: REG_W];
    assign Rd   = ir_reg[RD_LSB   +: REG_W];
    assign Rm   = ir_reg[RM_LSB   +: REG_W];

endmodule
